// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared IDs, FSM state types and fixed AXI field values for the SRAM-to-AXI bridge
package bridge_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;
    localparam logic [3:0] ID_WR   = 4'd1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } w_state_e;

    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/axi_wr_fsm.sv
// rtl/axi_wr_fsm.sv - single-beat store sequencer driving AW/W and collecting B
module axi_wr_fsm
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        take_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        idle_o,
    output logic        b_done_o,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    w_state_e    state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] awaddr_q;
    logic [2:0]  awsize_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        b_done_o  = 1'b0;
        bready    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (take_i) begin
                    state_d   = W_SEND;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_SEND: begin
                // AW and W complete independently; wait until both have handshaked
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    b_done_o = 1'b1;
                    state_d  = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            awsize_q  <= 3'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (take_i && state_q == W_IDLE) begin
                awaddr_q <= addr_i;
                awsize_q <= axi_size(size_i);
                wdata_q  <= wdata_i;
                wstrb_q  <= wstrb_i;
            end
        end
    end

    assign idle_o  = (state_q == W_IDLE);
    assign awvalid = (state_q == W_SEND) && !aw_done_q;
    assign wvalid  = (state_q == W_SEND) && !w_done_q;
    assign awid    = ID_WR;
    assign awaddr  = awaddr_q;
    assign awlen   = AXI_LEN;
    assign awsize  = awsize_q;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign wid     = ID_WR;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

endmodule

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - arbitrates fetch/data SRAM ports onto one AXI3 master and steers responses back
// Optional BRIDGE_RSP_REG_EN registers data_ok/rdata one cycle after the R/B handshake.
module axi_sram_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    ar_state_e   ar_state_q, ar_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [3:0]  arid_q, arid_d;
    logic        inst_rd_pend_q, inst_rd_pend_d;
    logic        data_pend_q, data_pend_d;
    logic        wr_pend_q, wr_pend_d;

    logic data_rd_take, inst_rd_take, wr_take, wr_idle;
    logic inst_rsp, data_rd_rsp, b_done;

    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

    // Loads wait behind any outstanding store so they never bypass it
    assign data_rd_take = (ar_state_q == AR_IDLE) && data_sram_req && !data_sram_wr
                          && !data_pend_q && !wr_pend_q;
    assign inst_rd_take = (ar_state_q == AR_IDLE) && inst_sram_req && !inst_rd_pend_q
                          && !data_rd_take;
    assign wr_take      = wr_idle && data_sram_req && data_sram_wr && !data_pend_q
                          && !(ar_state_q == AR_SEND && arid_q == ID_DATA);

    assign inst_sram_addr_ok = inst_rd_take;
    assign data_sram_addr_ok = data_rd_take || wr_take;

    // Gating on pend flags drops stale responses that arrive after a reset
    assign inst_rsp    = rvalid && (rid == ID_INST) && inst_rd_pend_q;
    assign data_rd_rsp = rvalid && (rid == ID_DATA) && data_pend_q;

    always_comb begin
        ar_state_d     = ar_state_q;
        araddr_d       = araddr_q;
        arsize_d       = arsize_q;
        arid_d         = arid_q;
        inst_rd_pend_d = inst_rd_pend_q;
        data_pend_d    = data_pend_q;
        wr_pend_d      = wr_pend_q;

        if (inst_rsp) inst_rd_pend_d = 1'b0;
        if (data_rd_rsp || b_done) data_pend_d = 1'b0;
        if (b_done) wr_pend_d = 1'b0;

        case (ar_state_q)
            AR_IDLE: begin
                if (data_rd_take) begin
                    ar_state_d  = AR_SEND;
                    araddr_d    = data_sram_addr;
                    arsize_d    = axi_size(data_sram_size);
                    arid_d      = ID_DATA;
                    data_pend_d = 1'b1;
                end else if (inst_rd_take) begin
                    ar_state_d     = AR_SEND;
                    araddr_d       = inst_sram_addr;
                    arsize_d       = axi_size(inst_sram_size);
                    arid_d         = ID_INST;
                    inst_rd_pend_d = 1'b1;
                end
            end
            AR_SEND: begin
                if (arready) ar_state_d = AR_IDLE;
            end
            default: ar_state_d = AR_IDLE;
        endcase

        if (wr_take) begin
            data_pend_d = 1'b1;
            wr_pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q     <= AR_IDLE;
            araddr_q       <= 32'd0;
            arsize_q       <= 3'd0;
            arid_q         <= ID_INST;
            inst_rd_pend_q <= 1'b0;
            data_pend_q    <= 1'b0;
            wr_pend_q      <= 1'b0;
        end else begin
            ar_state_q     <= ar_state_d;
            araddr_q       <= araddr_d;
            arsize_q       <= arsize_d;
            arid_q         <= arid_d;
            inst_rd_pend_q <= inst_rd_pend_d;
            data_pend_q    <= data_pend_d;
            wr_pend_q      <= wr_pend_d;
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = AXI_LEN;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign arvalid = (ar_state_q == AR_SEND);
    assign rready  = 1'b1;

    axi_wr_fsm u_wr_fsm (
        .clk      (clk),
        .reset    (reset),
        .take_i   (wr_take),
        .addr_i   (data_sram_addr),
        .size_i   (data_sram_size),
        .wdata_i  (data_sram_wdata),
        .wstrb_i  (data_sram_wstrb),
        .idle_o   (wr_idle),
        .b_done_o (b_done),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awlock   (awlock),
        .awcache  (awcache),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wid      (wid),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready)
    );

`ifdef BRIDGE_RSP_REG_EN
    logic        inst_data_ok_q, data_data_ok_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            rdata_q        <= 32'd0;
        end else begin
            inst_data_ok_q <= inst_rsp;
            data_data_ok_q <= data_rd_rsp || b_done;
            rdata_q        <= rdata;
        end
    end

    assign inst_sram_data_ok = inst_data_ok_q;
    assign data_sram_data_ok = data_data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign data_sram_rdata   = rdata_q;
`else
    assign inst_sram_data_ok = inst_rsp;
    assign data_sram_data_ok = data_rd_rsp || b_done;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;
`endif

endmodule
